// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared types and defaults for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  localparam int          C_INSTR_WIDTH = 32;
  localparam int          C_PC_STEP     = 4;
  localparam logic [63:0] C_RESET_PC    = 64'h0;
  localparam int          C_COUNT_WIDTH = 32;

endpackage

`default_nettype wire

// File: rtl/pc_register.sv
// ============================================================================
// Module   : pc_register
// Brief    : Program counter with load-over-increment priority and wraparound.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_register #(
  parameter int                  WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [WORDSIZE-1:0] load_value,
  input  logic                inc_en,
  output logic [WORDSIZE-1:0] pc
);

  localparam logic [WORDSIZE-1:0] C_STEP = WORDSIZE'(PC_STEP);

  logic [WORDSIZE-1:0] r_pc;

  // Increment is modulo 2^WORDSIZE by plain truncation of the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load_en) begin
      r_pc <= load_value;
    end else if (inc_en) begin
      r_pc <= r_pc + C_STEP;
    end
  end

  assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage: PC, imem req/ready, instr valid/ready, redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                  WORDSIZE    = 64,
  parameter int                  INSTR_WIDTH = C_INSTR_WIDTH,
  parameter logic [WORDSIZE-1:0] RESET_PC    = WORDSIZE'(C_RESET_PC),
  parameter int                  PC_STEP     = C_PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [WORDSIZE-1:0]      imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ready,
  input  logic [INSTR_WIDTH-1:0]   imem_data,
  input  logic                     branch_taken,
  input  logic [WORDSIZE-1:0]      branch_target,
  input  logic                     stall,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [WORDSIZE-1:0]      instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic                     fetch_fault,
  output logic [C_COUNT_WIDTH-1:0] instr_count
);

  fetch_state_t             r_state;
  fetch_state_t             w_state_next;
  logic [WORDSIZE-1:0]      w_pc;
  logic [INSTR_WIDTH-1:0]   r_instr;
  logic [WORDSIZE-1:0]      r_instr_pc;
  logic                     r_fault;
  logic [C_COUNT_WIDTH-1:0] r_count;

  logic w_redirect;
  logic w_aligned;
  logic w_capture;
  logic w_accept;

  assign w_redirect = branch_taken && (r_state != FAULT);
  assign w_aligned  = (branch_target[1:0] == 2'b00);
  assign imem_req   = !rst && (r_state == FETCH) && !stall;
  // A redirect in the same cycle as a response throws the response away.
  assign w_capture  = imem_req && imem_ready && !branch_taken;
  assign w_accept   = (r_state == HOLD) && instr_ready && !stall && !branch_taken;

  pc_register #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_en    (w_redirect && w_aligned),
    .load_value (branch_target),
    .inc_en     (w_capture),
    .pc         (w_pc)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_redirect) begin
      w_state_next = w_aligned ? FETCH : FAULT;
    end else if (w_capture) begin
      w_state_next = HOLD;
    end else if (w_accept) begin
      w_state_next = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_fault    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_instr    <= imem_data;
        r_instr_pc <= w_pc;
      end
      if (w_accept) begin
        r_count <= r_count + 1'b1;
      end
      if (w_redirect && !w_aligned) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign imem_addr   = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == HOLD);
  assign fetch_fault = r_fault;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Vector table, corner sequences and randomized model comparison.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_fault;
  logic [31:0] instr_count;

  logic [63:0] w_addr;
  logic        w_req;
  logic [31:0] w_instr;
  logic [63:0] w_ipc;
  logic        w_valid;
  logic        w_fault;
  logic [31:0] w_count;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_data(imem_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_fault(fetch_fault),
    .instr_count(instr_count)
  );

  // Wrap instance: free-running fetch with memory and consumer always ready.
  instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_req(w_req),
    .imem_ready(1'b1), .imem_data(32'h0000_0013), .branch_taken(1'b0),
    .branch_target(64'h0), .stall(1'b0), .instr(w_instr), .instr_pc(w_ipc),
    .instr_valid(w_valid), .instr_ready(1'b1), .fetch_fault(w_fault),
    .instr_count(w_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic b, input logic [63:0] t,
                       input logic r, input logic [31:0] d, input logic ir);
    stall = s; branch_taken = b; branch_target = t;
    imem_ready = r; imem_data = d; instr_ready = ir;
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        rdy;
    logic [31:0] data;
    logic        ir;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  // Reference model: "holding an instruction" and "dead" flags plus arithmetic PC.
  logic [63:0] m_pc;
  logic        m_have;
  logic        m_dead;
  logic [31:0] m_instr;
  logic [63:0] m_ipc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pc = 64'h0; m_have = 0; m_dead = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (rst || m_dead) return;
    if (branch_taken) begin
      m_have = 0;
      if (branch_target[1:0] == 2'b00) m_pc = branch_target;
      else m_dead = 1;
    end else if (stall) begin
      // frozen
    end else if (m_have) begin
      if (instr_ready) begin m_have = 0; m_cnt = m_cnt + 1; end
    end else if (imem_ready) begin
      m_instr = imem_data; m_ipc = m_pc; m_pc = m_pc + 64'd4; m_have = 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 64'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_low", {127'h0, imem_req}, 128'h0);
    chk("reset_state", {instr, instr_pc, instr_valid, fetch_fault, instr_count},
        {32'h0, 64'h0, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
    #1;
    chk("wrap_first_addr", {64'h0, w_addr}, {64'h0, 64'hFFFF_FFFF_FFFF_FFFC});
    @(posedge clk); #1;
    chk("wrap_next_addr", {w_valid, w_ipc, w_addr}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0});

    // Table: inputs, then pre-edge req/addr, post-edge valid/instr/instr_pc/count.
    vt.push_back('{0,0,0,    1,32'h13,1, 1,64'h0,  1,32'h13,64'h0,  0});
    vt.push_back('{0,0,0,    1,32'h13,1, 0,64'h4,  0,32'h13,64'h0,  1});
    vt.push_back('{0,0,0,    1,32'h13,1, 1,64'h4,  1,32'h13,64'h4,  1});
    vt.push_back('{0,0,0,    1,32'h13,1, 0,64'h8,  0,32'h13,64'h4,  2});
    vt.push_back('{0,0,0,    1,32'h13,1, 1,64'h8,  1,32'h13,64'h8,  2});
    vt.push_back('{0,0,0,    1,32'h13,1, 0,64'hC,  0,32'h13,64'h8,  3});
    vt.push_back('{0,0,0,    1,32'h13,0, 1,64'hC,  1,32'h13,64'hC,  3});
    for (int i = 0; i < 5; i++)
      vt.push_back('{0,0,0,  1,32'hDEAD0000+i,0, 0,64'h10, 1,32'h13,64'hC, 3});
    vt.push_back('{0,0,0,    1,32'hBEEF,1, 0,64'h10, 0,32'h13,64'hC,  4});
    vt.push_back('{0,1,64'h100, 1,32'hAAAA,1, 1,64'h10, 0,32'h13,64'hC, 4});
    vt.push_back('{0,0,0,    0,32'h0,1,  1,64'h100, 0,32'h13,64'hC, 4});
    for (int i = 0; i < 3; i++)
      vt.push_back('{1,0,0,  1,32'h55,1, 0,64'h100, 0,32'h13,64'hC, 4});
    vt.push_back('{0,0,0,    1,32'h33,1, 1,64'h100, 1,32'h33,64'h100, 4});
    vt.push_back('{1,0,0,    1,32'h0,1,  0,64'h104, 1,32'h33,64'h100, 4});
    vt.push_back('{0,0,0,    1,32'h0,1,  0,64'h104, 0,32'h33,64'h100, 5});
    vt.push_back('{1,1,64'h200, 1,32'h0,1, 0,64'h104, 0,32'h33,64'h100, 5});
    vt.push_back('{0,0,0,    0,32'h0,1,  1,64'h200, 0,32'h33,64'h100, 5});

    foreach (vt[i]) begin
      drive(vt[i].stall, vt[i].br, vt[i].tgt, vt[i].rdy, vt[i].data, vt[i].ir);
      #1;
      chk($sformatf("vec%0d_req_addr", i), {63'h0, imem_req, imem_addr},
          {63'h0, vt[i].e_req, vt[i].e_addr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), {instr_valid, instr, instr_pc, instr_count},
          {vt[i].e_valid, vt[i].e_instr, vt[i].e_ipc, vt[i].e_cnt});
    end

    // Misaligned redirect: terminal fault, later redirects ignored.
    drive(0, 1, 64'h102, 1, 32'h77, 1);
    @(posedge clk); #1;
    chk("fault_set", {fetch_fault, imem_req, instr_valid, imem_addr},
        {1'b1, 1'b0, 1'b0, 64'h200});
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 64'h300, 1, 32'h77, 1);
      @(posedge clk); #1;
      chk($sformatf("fault_sticky%0d", i), {fetch_fault, imem_req, instr_valid, imem_addr},
          {1'b1, 1'b0, 1'b0, 64'h200});
    end
    // Asynchronous reset mid-cycle with a response pending.
    drive(0, 0, 64'h0, 1, 32'h99, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {fetch_fault, imem_req, instr_valid, imem_addr, instr_count, instr},
        {1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 32'h0});
    @(posedge clk); #1;
    chk("rst_ignores_resp", {instr_valid, instr, instr_pc}, {1'b0, 32'h0, 64'h0});
    rst = 1'b0;

    // Randomized run against the reference model.
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            {$urandom(), $urandom()} & (($urandom_range(0, 15) == 0) ? 64'hFFFF : 64'hFFFC),
            $urandom_range(0, 1), $urandom(), $urandom_range(0, 2) != 0);
      if (rst) model_reset();
      #1;
      chk($sformatf("rand%0d", c),
          {imem_req, imem_addr, instr_valid, fetch_fault, instr_count},
          {!rst && !m_dead && !m_have && !stall, m_pc, m_have, m_dead, m_cnt});
      if (m_have)
        chk($sformatf("rand%0d_instr", c), {instr, instr_pc}, {m_instr, m_ipc});
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
